// File: rtl/data_out_8_to_64_pkg.sv
// Shared word/byte geometry and defaults for the 8-to-64 receive reassembler.
package data_out_8_to_64_pkg;

    localparam int unsigned BYTES_PER_WORD     = 8;
    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned WORD_W             = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned BCNT_W             = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 21700;
    localparam int unsigned DEF_CNT_W          = 15;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BCNT_W-1:0] bcnt_t;

    // Append a byte at the LSB end so the first byte received ends up in the MSB lane.
    function automatic word_t shift_in_byte(word_t w, byte_t b);
        return {w[WORD_W-BYTE_W-1:0], b};
    endfunction

endpackage

// File: rtl/data_out_8_to_64_if.sv
// Byte-in / word-out bus of the receive reassembler.
interface data_out_8_to_64_if;
    import data_out_8_to_64_pkg::*;

    byte_t data_8;
    logic  rx_done;
    word_t data_64;
    logic  data_64_valid;
    bcnt_t byte_cnt;
    logic  timeout_err;
    logic  busy;

    modport master (
        output data_8, rx_done,
        input  data_64, data_64_valid, byte_cnt, timeout_err, busy
    );

    modport slave (
        input  data_8, rx_done,
        output data_64, data_64_valid, byte_cnt, timeout_err, busy
    );

endinterface

// File: rtl/data_out_8_to_64_rise_edge_detect.sv
// Registered-history rising-edge detector: one-cycle pulse per low-to-high transition.
module rise_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/data_out_8_to_64.sv
// Reassembles eight UART bytes (MSB byte first) into a 64-bit word; an
// inter-byte timeout discards partial words to recover framing.
module data_out_8_to_64
    import data_out_8_to_64_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    data_out_8_to_64_if.slave  bus
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_e;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bcnt_t            LAST_BYTE  = bcnt_t'(BYTES_PER_WORD - 1);

    state_e           state_q, state_d;
    word_t            shift_q, shift_d;
    word_t            data_q, data_d;
    bcnt_t            cnt_q, cnt_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             valid_q, valid_d;
    logic             terr_q, terr_d;

    logic             rise;
    logic             last_byte;
    logic             expired;
    word_t            shifted;

    rise_edge_detect u_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (bus.rx_done),
        .pulse_o (rise)
    );

    assign shifted   = shift_in_byte(shift_q, bus.data_8);
    assign last_byte = (cnt_q == LAST_BYTE);
    assign expired   = (timer_q == TIMER_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            valid_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            valid_q <= valid_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rise) state_d = COLLECT;
            end
            COLLECT: begin
                // A rise on the expiry cycle still counts as a byte.
                if (rise) begin
                    if (last_byte) state_d = IDLE;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        valid_d = 1'b0;
        terr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    shift_d = shifted;
                    cnt_d   = bcnt_t'(1);
                    timer_d = '0;
                end
            end
            COLLECT: begin
                if (rise) begin
                    shift_d = shifted;
                    timer_d = '0;
                    if (last_byte) begin
                        data_d  = shifted;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + bcnt_t'(1);
                    end
                end else if (expired) begin
                    cnt_d   = '0;
                    timer_d = '0;
                    terr_d  = 1'b1;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    assign bus.data_64       = data_q;
    assign bus.data_64_valid = valid_q;
    assign bus.byte_cnt      = cnt_q;
    assign bus.timeout_err   = terr_q;
    assign bus.busy          = (cnt_q != '0);

endmodule

// File: tb/tb_data_out_8_to_64.sv
// Directed bench for data_out_8_to_64 with a queue-based reference model checked every cycle.
module tb_data_out_8_to_64;
    import data_out_8_to_64_pkg::*;

    localparam int unsigned T = 5000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_out_8_to_64_if bus();

    data_out_8_to_64 #(.TIMEOUT_CYCLES(T), .CNT_W(13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes of the open word in a queue, timeout by elapsed cycles since last byte.
    byte_t  m_q[$];
    word_t  m_data  = '0;
    logic   m_valid = 1'b0;
    logic   m_terr  = 1'b0;
    logic   m_prev  = 1'b0;
    longint m_cyc   = 0;
    longint m_last  = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_terr  = 1'b0;
            m_prev  = 1'b0;
            m_cyc   = 0;
            m_last  = 0;
        end else begin
            m_cyc++;
            m_valid = 1'b0;
            m_terr  = 1'b0;
            if (bus.rx_done && !m_prev) begin
                m_q.push_back(bus.data_8);
                m_last = m_cyc;
                if (m_q.size() == BYTES_PER_WORD) begin
                    for (int i = 0; i < BYTES_PER_WORD; i++)
                        m_data[WORD_W-1-BYTE_W*i -: BYTE_W] = m_q[i];
                    m_valid = 1'b1;
                    m_q.delete();
                end
            end else if (m_q.size() != 0 && (m_cyc - m_last) == longint'(T)) begin
                m_q.delete();
                m_terr = 1'b1;
            end
            m_prev = bus.rx_done;
        end
    end

    int dut_vcnt = 0;
    int dut_tcnt = 0;

    always @(negedge clk) begin
        chk("data_64",       bus.data_64, m_data);
        chk("data_64_valid", 64'(bus.data_64_valid), 64'(m_valid));
        chk("byte_cnt",      64'(bus.byte_cnt), 64'(m_q.size()));
        chk("timeout_err",   64'(bus.timeout_err), 64'(m_terr));
        chk("busy",          64'(bus.busy), 64'(m_q.size() != 0));
        if (bus.data_64_valid === 1'b1) dut_vcnt++;
        if (bus.timeout_err === 1'b1) dut_tcnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Rises of consecutive send() calls are hold+gap edges apart.
    task automatic send(input byte_t b, input int hold, input int gap);
        bus.data_8  = b;
        bus.rx_done = 1'b1;
        step(hold);
        bus.rx_done = 1'b0;
        step(gap);
    endtask

    task automatic send_word(input word_t w, input int hold, input int gap);
        for (int i = 0; i < BYTES_PER_WORD; i++)
            send(w[WORD_W-1-BYTE_W*i -: BYTE_W], hold, gap);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w;
        bus.rx_done = 1'b0;
        bus.data_8  = '0;
        step(3);
        chk("reset_data_64",  bus.data_64, 64'h0);
        chk("reset_byte_cnt", 64'(bus.byte_cnt), 64'h0);
        chk("reset_busy",     64'(bus.busy), 64'h0);
        rst_n = 1'b1;
        step(2);

        // Single word, widely spaced bytes
        send_word(64'hbb941c2b7e1d731b, 2, 4340);
        chk("single_data",     bus.data_64, 64'hbb941c2b7e1d731b);
        chk("single_model",    m_data, 64'hbb941c2b7e1d731b);
        chk("single_vcnt",     64'(dut_vcnt), 64'd1);
        chk("single_tcnt",     64'(dut_tcnt), 64'd0);
        chk("single_byte_cnt", 64'(bus.byte_cnt), 64'd0);

        // Held flag: one byte per assertion
        w = 64'hbca16b888f3cafb4;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            send(w[WORD_W-1-BYTE_W*i -: BYTE_W], 5, 3);
            chk("held_byte_cnt", 64'(bus.byte_cnt), 64'((i + 1) % 8));
        end
        chk("held_data", bus.data_64, 64'hbca16b888f3cafb4);
        chk("held_vcnt", 64'(dut_vcnt), 64'd2);

        // Timeout recovery
        send(8'h11, 2, 2);
        send(8'h22, 2, 2);
        send(8'h33, 2, 2);
        chk("to_partial_cnt", 64'(bus.byte_cnt), 64'd3);
        step(T + 5);
        chk("to_tcnt",     64'(dut_tcnt), 64'd1);
        chk("to_byte_cnt", 64'(bus.byte_cnt), 64'd0);
        chk("to_data_kept", bus.data_64, 64'hbca16b888f3cafb4);
        send_word(64'h0102030405060708, 2, 2);
        chk("to_next_data", bus.data_64, 64'h0102030405060708);
        chk("to_next_vcnt", 64'(dut_vcnt), 64'd3);

        // Boundary: second rise exactly at expiry is accepted
        send(8'hA1, 1, T - 1);
        send(8'hA2, 1, 2);
        chk("bnd_in_cnt",  64'(bus.byte_cnt), 64'd2);
        chk("bnd_in_tcnt", 64'(dut_tcnt), 64'd1);
        step(T + 5);
        chk("bnd_in_expire_tcnt", 64'(dut_tcnt), 64'd2);

        // Boundary: one cycle later times out, byte starts a new word
        send(8'hB1, 1, T);
        send(8'hB2, 1, 2);
        chk("bnd_out_tcnt", 64'(dut_tcnt), 64'd3);
        chk("bnd_out_cnt",  64'(bus.byte_cnt), 64'd1);
        for (int i = 0; i < 7; i++)
            send(byte_t'(8'hC3 + i), 1, 1);
        chk("bnd_out_data", bus.data_64, 64'hB2C3C4C5C6C7C8C9);
        chk("bnd_out_vcnt", 64'(dut_vcnt), 64'd4);

        // Reset mid-word
        send(8'h55, 2, 2);
        send(8'h66, 2, 2);
        send(8'h77, 2, 2);
        send(8'h88, 2, 2);
        send(8'h99, 2, 2);
        chk("rst_pre_cnt", 64'(bus.byte_cnt), 64'd5);
        rst_n = 1'b0;
        #2;
        chk("rst_async_data",  bus.data_64, 64'h0);
        chk("rst_async_cnt",   64'(bus.byte_cnt), 64'd0);
        chk("rst_async_busy",  64'(bus.busy), 64'd0);
        chk("rst_async_valid", 64'(bus.data_64_valid), 64'd0);
        chk("rst_async_terr",  64'(bus.timeout_err), 64'd0);
        step(3);
        rst_n = 1'b1;
        step(2);
        chk("rst_vcnt", 64'(dut_vcnt), 64'd4);
        chk("rst_tcnt", 64'(dut_tcnt), 64'd3);
        send_word(64'hDEADBEEF01234567, 1, 1);
        chk("rst_after_data", bus.data_64, 64'hDEADBEEF01234567);
        chk("rst_after_vcnt", 64'(dut_vcnt), 64'd5);

        // Back-to-back words at minimum rise spacing
        send_word(64'h0f1e2d3c4b5a6978, 1, 1);
        chk("b2b_first_data", bus.data_64, 64'h0f1e2d3c4b5a6978);
        send_word(64'h8796a5b4c3d2e1f0, 1, 1);
        chk("b2b_second_data", bus.data_64, 64'h8796a5b4c3d2e1f0);
        chk("b2b_vcnt", 64'(dut_vcnt), 64'd7);
        chk("b2b_tcnt", 64'(dut_tcnt), 64'd3);

        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
